// File: rtl/pulse_meter_pkg.sv
// Shared types and helpers for the pulse length meter: FSM state encoding
// and the saturation limit derived from the length width.
package pulse_meter_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_e;

    // Largest value representable in a length field of the given width.
    function automatic int unsigned length_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/pulse_input_synchronizer.sv
// Multi-flop synchronizer for the measured pulse; a plain wire when
// SYNC_STAGES is 0 so the meter can also sit in the pulse's own domain.
module pulse_input_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pulse,
    output logic o_pulse
);

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign o_pulse = i_pulse;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= i_pulse;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign o_pulse = r_sync[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/pulse_length_meter.sv
// Measures the high time of each input pulse in clocks and presents it
// through a valid/ready result register with saturation and overrun flags.
module pulse_length_meter
    import pulse_meter_pkg::*;
#(
    parameter int DEEP_PULSE_LENGTH_BITS = 5,
    parameter int SYNC_STAGES            = 2
) (
    input  logic                              IN_CLOCK,
    input  logic                              IN_RESET_N,
    input  logic                              IN_PULSE,
    input  logic                              IN_READY,
    output logic                              OUT_VALID,
    output logic [DEEP_PULSE_LENGTH_BITS-1:0] OUT_LENGTH_CLKS,
    output logic                              OUT_SATURATED,
    output logic                              OUT_OVERRUN
);

    localparam int W = DEEP_PULSE_LENGTH_BITS;
    localparam logic [W-1:0] LENGTH_MAX = W'(length_max(W));
    localparam logic [W-1:0] CNT_ONE    = W'(1);
    localparam logic [0:0]   L_IDLE     = IDLE;
    localparam logic [0:0]   L_MEASURE  = MEASURE;

    logic         w_s;
    logic [0:0]   r_state;
    logic [W-1:0] r_cnt;
    logic         r_sat;
    logic         r_valid;
    logic [W-1:0] r_length;
    logic         r_saturated;
    logic         r_overrun;

    logic         w_complete;
    logic         w_load;
    logic [W-1:0] w_cnt_inc;

    pulse_input_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk   (IN_CLOCK),
        .i_rst_n (IN_RESET_N),
        .i_pulse (IN_PULSE),
        .o_pulse (w_s)
    );

    // Counter holds at LENGTH_MAX instead of wrapping.
    assign w_cnt_inc  = (r_cnt == LENGTH_MAX) ? r_cnt : r_cnt + CNT_ONE;
    assign w_complete = (r_state == L_MEASURE) && !w_s;
    assign w_load     = w_complete && (!r_valid || IN_READY);

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            r_state <= L_IDLE;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                L_IDLE: begin
                    if (w_s) begin
                        r_state <= L_MEASURE;
                        r_cnt   <= CNT_ONE;
                        r_sat   <= (CNT_ONE == LENGTH_MAX);
                    end
                end
                L_MEASURE: begin
                    if (w_s) begin
                        r_cnt <= w_cnt_inc;
                        r_sat <= (w_cnt_inc == LENGTH_MAX);
                    end else begin
                        r_state <= L_IDLE;
                    end
                end
                default: r_state <= L_IDLE;
            endcase
        end
    end

    // A completion colliding with a held, unaccepted result is dropped.
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            r_valid     <= 1'b0;
            r_length    <= '0;
            r_saturated <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= w_complete && r_valid && !IN_READY;
            if (w_load) begin
                r_valid     <= 1'b1;
                r_length    <= r_cnt;
                r_saturated <= r_sat;
            end else if (r_valid && IN_READY) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign OUT_VALID       = r_valid;
    assign OUT_LENGTH_CLKS = r_length;
    assign OUT_SATURATED   = r_saturated;
    assign OUT_OVERRUN     = r_overrun;

endmodule
